// File: rtl/raccoon_testregs_wd.sv
// Raccoon ring test/status slave: scratch bank, byte-enable writes, 64-bit cycle
// counter with atomic high-word shadow, and a progress watchdog that raises TEST_FAIL.
module raccoon_testregs_wd #(
    parameter logic [19:0] ADDR_MASK      = 20'hFFFC0,
    parameter logic [19:0] ADDR_BASE      = 20'hFFFC0,
    parameter int unsigned NUM_SCRATCH    = 8,
    parameter logic [31:0] WDOG_RESET     = 32'd0,
    parameter logic [31:0] WDOG_FAIL_CODE = 32'hDEAD0D06
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] TEST_PROGRESS,
    output logic [31:0] TEST_FAIL,
    output logic [31:0] TEST_PASS,
    output logic        WDOG_EXPIRED,
    input  logic [63:0] RaccIn,
    output logic [63:0] RaccOut
);
    typedef enum logic [1:0] {WD_OFF, WD_RUN, WD_EXP} wd_state_e;

    logic [63:0]      din_q, din_d1_q, out_q, cyc_q;
    logic [31:0]      shadow_q, prog_q, fail_q, pass_q, wload_q, wcnt_q;
    logic             wexp_q;
    wd_state_e        state_q, state_d;
    logic [7:0][31:0] scr;

    logic [17:0] addr;
    logic [3:0]  be, sel;
    logic [31:0] wdata, bmask, rdata;
    logic        hit, wr, rd_lo, wr_prog, wr_fail, wr_pass, wr_wload, w1c;
    logic [31:0] prog_m, fail_m, pass_m, wload_m;
    logic        fire, force_fail, running;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [31:0] m);
        return (old & ~m) | (nw & m);
    endfunction

    // Register access happens on the din_d1 stage; the response is registered into RaccOut
    assign addr     = din_d1_q[49:32];
    assign be       = din_d1_q[53:50];
    assign sel      = addr[3:0];
    assign wdata    = din_d1_q[31:0];
    assign bmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign hit      = (din_d1_q[63:62] == 2'b11) &&
                      (({addr, 2'b00} & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
    assign wr       = hit && (be != 4'd0);
    assign rd_lo    = hit && !wr && (sel == 4'd4);
    assign wr_prog  = wr && (sel == 4'd1);
    assign wr_fail  = wr && (sel == 4'd2);
    assign wr_pass  = wr && (sel == 4'd3);
    assign wr_wload = wr && (sel == 4'd6);
    assign w1c      = wr && (sel == 4'd7) && be[0] && wdata[0];

    assign prog_m  = merge(prog_q, wdata, bmask);
    assign fail_m  = merge(fail_q, wdata, bmask);
    assign pass_m  = merge(pass_q, wdata, bmask);
    assign wload_m = merge(wload_q, wdata, bmask);

    for (genvar n = 0; n < 8; n++) begin : g_scr
        if (n < NUM_SCRATCH) begin : g_impl
            logic [31:0] scr_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    scr_q <= '0;
                else if (wr && sel[3] && (sel[2:0] == 3'(n)))
                    scr_q <= merge(scr_q, wdata, bmask);
            end
            assign scr[n] = scr_q;
        end else begin : g_none
            assign scr[n] = '0;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            4'd0:    rdata = {24'd0, din_d1_q[61:54]};
            4'd1:    rdata = prog_q;
            4'd2:    rdata = fail_q;
            4'd3:    rdata = pass_q;
            4'd4:    rdata = cyc_q[31:0];
            4'd5:    rdata = shadow_q;
            4'd6:    rdata = wload_q;
            4'd7:    rdata = {30'd0, running, wexp_q};
            default: rdata = scr[sel[2:0]];
        endcase
    end

    // Watchdog FSM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= (WDOG_RESET != 32'd0) ? WD_RUN : WD_OFF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WD_RUN:  if (fire) state_d = WD_EXP;
            default: state_d = state_q;
        endcase
        if (wr_wload) state_d = (wload_m != 32'd0) ? WD_RUN : WD_OFF;
    end

    // A kick or reload in the same cycle as count==1 pre-empts expiry
    always_comb begin
        running    = (state_q == WD_RUN);
        fire       = running && (wcnt_q == 32'd1) && !wr_prog && !wr_wload;
        force_fail = fire || (state_q == WD_EXP);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            wcnt_q <= WDOG_RESET;
        else if (wr_wload)
            wcnt_q <= wload_m;
        else if (running) begin
            if (wr_prog)   wcnt_q <= wload_q;
            else if (fire) wcnt_q <= '0;
            else           wcnt_q <= wcnt_q - 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            din_q    <= '0;
            din_d1_q <= '0;
            out_q    <= '0;
            cyc_q    <= '0;
            shadow_q <= '0;
            prog_q   <= '0;
            fail_q   <= '0;
            pass_q   <= '0;
            wload_q  <= WDOG_RESET;
            wexp_q   <= 1'b0;
        end else begin
            din_q    <= RaccIn;
            din_d1_q <= din_q;
            out_q    <= hit ? {2'b10, din_d1_q[61:32], rdata} : din_d1_q;
            cyc_q    <= cyc_q + 64'd1;
            if (rd_lo)    shadow_q <= cyc_q[63:32];
            if (wr_prog)  prog_q   <= prog_m;
            if (wr_pass)  pass_q   <= pass_m;
            if (wr_wload) wload_q  <= wload_m;
            // Bus write to FAIL beats the watchdog code
            if (wr_fail)
                fail_q <= fail_m;
            else if (force_fail && (fail_q == 32'd0))
                fail_q <= WDOG_FAIL_CODE;
            if (fire)     wexp_q <= 1'b1;
            else if (w1c) wexp_q <= 1'b0;
        end
    end

    assign RaccOut       = out_q;
    assign TEST_PROGRESS = prog_q;
    assign TEST_FAIL     = fail_q;
    assign TEST_PASS     = pass_q;
    assign WDOG_EXPIRED  = wexp_q;
endmodule

// File: tb/tb_raccoon_testregs_wd.sv
// Bench for raccoon_testregs_wd: per-cycle compare against a behavioural register/ring
// model, plus directed transactions with hand-computed expectations.
module tb_raccoon_testregs_wd;
    localparam int          NS   = 6;
    localparam logic [31:0] CODE = 32'hDEAD0D06;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [63:0] RaccIn = '0;
    logic [63:0] RaccOut;
    logic [31:0] TEST_PROGRESS, TEST_FAIL, TEST_PASS;
    logic        WDOG_EXPIRED;

    int n_chk = 0;
    int n_fail = 0;

    raccoon_testregs_wd #(.NUM_SCRATCH(NS)) dut (
        .CLK(CLK), .RST(RST),
        .TEST_PROGRESS(TEST_PROGRESS), .TEST_FAIL(TEST_FAIL), .TEST_PASS(TEST_PASS),
        .WDOG_EXPIRED(WDOG_EXPIRED), .RaccIn(RaccIn), .RaccOut(RaccOut)
    );

    initial forever #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    logic [63:0] m_cyc, m_out, pipe0, pipe1;
    logic [31:0] m_prog, m_fail, m_pass, m_shadow, m_wload, m_wcnt;
    logic [31:0] m_scr [NS];
    int          m_mode;   // 0 off, 1 running, 2 expired
    bit          m_exp;
    int          frc_cnt = 0;
    int          frc_done = 0;
    logic [63:0] frc_val = '0;

    task automatic m_reset();
        m_cyc = '0; m_out = '0; pipe0 = '0; pipe1 = '0;
        m_prog = '0; m_fail = '0; m_pass = '0; m_shadow = '0; m_wload = '0; m_wcnt = '0;
        for (int i = 0; i < NS; i++) m_scr[i] = '0;
        m_mode = 0; m_exp = 0;
    endtask

    task automatic m_access(input logic [63:0] p);
        logic [19:0] ba;
        logic [31:0] old, msk, nv;
        int          idx;
        bit          hit, wr, kick, ld, fire;
        ba  = {p[49:32], 2'b00};
        hit = (p[63:62] == 2'b11) && (ba >= 20'hFFFC0);
        idx = hit ? int'(ba - 20'hFFFC0) / 4 : -1;
        old = '0;
        case (idx)
            0: old = {24'd0, p[61:54]};
            1: old = m_prog;
            2: old = m_fail;
            3: old = m_pass;
            4: old = m_cyc[31:0];
            5: old = m_shadow;
            6: old = m_wload;
            7: old = {30'd0, m_mode == 1, m_exp};
            default: if (idx >= 8 && idx - 8 < NS) old = m_scr[idx - 8];
        endcase
        for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{p[50+b]}};
        wr    = hit && (p[53:50] != 4'd0);
        nv    = (old & ~msk) | (p[31:0] & msk);
        m_out = hit ? {2'b10, p[61:32], old} : p;
        kick  = wr && idx == 1;
        ld    = wr && idx == 6;
        fire  = (m_mode == 1) && (m_wcnt == 32'd1) && !kick && !ld;
        if ((fire || m_mode == 2) && m_fail == 32'd0) m_fail = CODE;
        if (wr)
            case (idx)
                1: m_prog = nv;
                2: m_fail = nv;
                3: m_pass = nv;
                6: m_wload = nv;
                default: if (idx >= 8 && idx - 8 < NS) m_scr[idx - 8] = nv;
            endcase
        if (hit && !wr && idx == 4) m_shadow = m_cyc[63:32];
        if (wr && idx == 7 && p[50] && p[0]) m_exp = 0;
        if (fire) m_exp = 1;
        if (ld) begin
            m_wcnt = nv;
            m_mode = (nv != 32'd0) ? 1 : 0;
        end else if (m_mode == 1) begin
            if (kick)      m_wcnt = m_wload;
            else if (fire) m_mode = 2;
            else           m_wcnt = m_wcnt - 32'd1;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            if (RST) m_reset();
            else begin
                if (frc_cnt != frc_done) begin
                    m_cyc    = frc_val;
                    frc_done = frc_cnt;
                end
                m_access(pipe1);
                pipe1 = pipe0;
                pipe0 = RaccIn;
                m_cyc = m_cyc + 64'd1;
            end
        end
    end

    // ---------------- checking / stimulus ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [63:0] pkt);
        @(negedge CLK);
        if (!RST) begin
            chk("raccout", RaccOut, m_out);
            chk("progress", {32'd0, TEST_PROGRESS}, {32'd0, m_prog});
            chk("fail", {32'd0, TEST_FAIL}, {32'd0, m_fail});
            chk("pass", {32'd0, TEST_PASS}, {32'd0, m_pass});
            chk("expired", {63'd0, WDOG_EXPIRED}, {63'd0, m_exp});
        end
        RaccIn = pkt;
    endtask

    task automatic xact(input logic [63:0] pkt, output logic [63:0] rsp);
        step(pkt);
        repeat (3) step('0);
        rsp = RaccOut;
    endtask

    function automatic logic [63:0] pk(input logic [7:0] tid, input logic [3:0] be,
                                       input logic [7:0] off, input logic [31:0] d);
        logic [19:0] ba;
        ba = 20'hFFFC0 + {12'd0, off};
        return {2'b11, tid, be, ba[19:2], d};
    endfunction

    logic [63:0] r, r_lo, r_hi;
    logic [63:0] s [8];
    logic [63:0] q [8];

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_raccout", RaccOut, 64'd0);
        chk("rst_fail", {32'd0, TEST_FAIL}, 64'd0);
        chk("rst_pass", {32'd0, TEST_PASS}, 64'd0);
        chk("rst_expired", {63'd0, WDOG_EXPIRED}, 64'd0);
        RST = 1'b0;

        // thread id read
        xact(pk(8'h5A, 4'h0, 8'h00, 32'h0), r);
        chk("tid_rsp", r, {2'b10, 8'h5A, 4'h0, 18'h3FFF0, 32'h0000005A});

        // byte-enable partial write
        xact(pk(8'h01, 4'b0101, 8'h0C, 32'h11223344), r);
        chk("pass_wr_old", {32'd0, r[31:0]}, 64'd0);
        chk("pass_out", {32'd0, TEST_PASS}, 64'h00220044);
        xact(pk(8'h01, 4'h0, 8'h0C, 32'h0), r);
        chk("pass_rd", {32'd0, r[31:0]}, 64'h00220044);

        // cycle counter shadow: LO read sees 1_FFFFFFFE
        step('0);
        force dut.cyc_q = 64'h1_FFFF_FFFB;
        #1 release dut.cyc_q;
        frc_val = 64'h1_FFFF_FFFB;
        frc_cnt++;
        step(pk(8'h02, 4'h0, 8'h10, 32'h0));
        step(pk(8'h02, 4'h0, 8'h14, 32'h0));
        step('0);
        step('0);
        r_lo = RaccOut;
        step('0);
        r_hi = RaccOut;
        chk("cyc_lo", {32'd0, r_lo[31:0]}, 64'hFFFFFFFE);
        chk("cyc_hi", {32'd0, r_hi[31:0]}, 64'h1);

        // back-to-back hits and misses
        s[0] = pk(8'h10, 4'hF, 8'h20, 32'hA5A5A5A5);
        s[1] = {2'b11, 8'h03, 4'hF, 18'h00001, 32'h12345678};
        s[2] = {2'b10, 8'h04, 4'h0, 18'h3FFF0, 32'hCAFEF00D};
        s[3] = pk(8'h11, 4'h0, 8'h20, 32'h0);
        s[4] = pk(8'h12, 4'hF, 8'h38, 32'h00001234);
        s[5] = pk(8'h13, 4'h0, 8'h38, 32'h0);
        s[6] = '0;
        s[7] = pk(8'h33, 4'h0, 8'h00, 32'h0);
        for (int i = 0; i < 11; i++) begin
            step(i < 8 ? s[i] : 64'd0);
            if (i >= 3) q[i-3] = RaccOut;
        end
        chk("miss_passthru", q[1], s[1]);
        chk("resp_passthru", q[2], s[2]);
        chk("scr0_rd", q[3], {2'b10, 8'h11, 4'h0, 18'h3FFF8, 32'hA5A5A5A5});
        chk("scr6_rd", {32'd0, q[5][31:0]}, 64'd0);
        chk("tid33_rd", {32'd0, q[7][31:0]}, 64'h33);

        // watchdog 100, no kicks
        xact(pk(8'h20, 4'hF, 8'h18, 32'd100), r);
        repeat (99) step('0);
        chk("wd100_early", {63'd0, WDOG_EXPIRED}, 64'd0);
        step('0);
        chk("wd100_exp", {63'd0, WDOG_EXPIRED}, 64'd1);
        chk("wd100_fail", {32'd0, TEST_FAIL}, {32'd0, CODE});
        xact(pk(8'h20, 4'h0, 8'h1C, 32'h0), r);
        chk("wd_status_exp", {32'd0, r[31:0]}, 64'h1);
        xact(pk(8'h20, 4'hF, 8'h18, 32'd0), r);
        xact(pk(8'h20, 4'h1, 8'h1C, 32'h1), r);
        xact(pk(8'h20, 4'hF, 8'h08, 32'h0), r);
        chk("wd_clr_exp", {63'd0, WDOG_EXPIRED}, 64'd0);
        chk("wd_clr_fail", {32'd0, TEST_FAIL}, 64'd0);

        // kick on count==1 wins; later expiry collides with FAIL write
        step(pk(8'h21, 4'hF, 8'h18, 32'd3));
        repeat (2) step('0);
        step(pk(8'h21, 4'hF, 8'h04, 32'h0000_0001));
        repeat (2) step('0);
        step(pk(8'h21, 4'hF, 8'h08, 32'h0000_0077));
        repeat (3) step('0);
        chk("coll_fail", {32'd0, TEST_FAIL}, 64'h77);
        chk("coll_exp", {63'd0, WDOG_EXPIRED}, 64'd1);
        xact(pk(8'h21, 4'hF, 8'h18, 32'd0), r);
        xact(pk(8'h21, 4'h1, 8'h1C, 32'h1), r);
        xact(pk(8'h21, 4'hF, 8'h08, 32'h0), r);

        // watchdog 10, kicked every 8 cycles
        xact(pk(8'h22, 4'hF, 8'h18, 32'd10), r);
        for (int k = 0; k < 25; k++) begin
            step(pk(8'h22, 4'hF, 8'h04, k));
            repeat (7) step('0);
        end
        chk("kick_noexp", {63'd0, WDOG_EXPIRED}, 64'd0);
        xact(pk(8'h22, 4'h0, 8'h1C, 32'h0), r);
        chk("kick_running", {32'd0, r[31:0]}, 64'h2);
        xact(pk(8'h22, 4'hF, 8'h18, 32'd0), r);

        // reset mid-packet drops the write
        step(pk(8'h23, 4'hF, 8'h0C, 32'hFFFFFFFF));
        step('0);
        RST = 1'b1;
        #1;
        chk("rst_mid_raccout", RaccOut, 64'd0);
        chk("rst_mid_prog", {32'd0, TEST_PROGRESS}, 64'd0);
        repeat (2) step('0);
        RST = 1'b0;
        repeat (4) step('0);
        chk("rst_mid_pass", {32'd0, TEST_PASS}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
